debug_dump_ctrl: RTL and testbench
==================================

// Module: debug_dump_ctrl
// PURPOSE
//  Host-command sequencer for the pipeline debug path. Decodes command bytes from the
//  UART receiver, gates the pipeline clock-enable (run / single-step / halt), triggers
//  the debug FIFO snapshot write, then drains the FIFO byte-by-byte into the UART
//  transmitter and appends a terminator byte. Sits between uart_rx, the debug Fifo and uart_tx.
// PARAMETERS
//  B          8        data width of FIFO bytes / UART bytes
//  N_BYTES    4        max bytes sent per dump (snapshot size)
//  TX_TIMEOUT 100000   cycles allowed per byte in WAIT_TX before abort
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  reset         in   1  asynchronous, active-low reset
//  rx_done_tick  in   1  1-cycle strobe: rx_data valid
//  rx_data       in   B  received command byte
//  fifo_empty    in   1  debug FIFO empty flag
//  fifo_r_data   in   B  debug FIFO head byte (combinational, valid while !fifo_empty)
//  tx_done_tick  in   1  1-cycle strobe: UART tx finished current byte
//  fifo_wr       out  1  1-cycle pulse: capture snapshot into FIFO
//  fifo_rd       out  1  1-cycle pulse: pop FIFO head
//  tx_start      out  1  1-cycle pulse: start transmitting tx_data
//  tx_data       out  B  byte to transmit, held stable until tx_done_tick
//  pipe_en       out  1  pipeline clock-enable (1 = pipeline advances this cycle)
//  busy          out  1  high in any state other than IDLE
//  tx_err        out  1  sticky: TX timeout occurred; cleared by next accepted command
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, run_mode=0, all outputs 0, counters 0.
//  Commands (IDLE only): CMD_STEP 's'=8'h73, CMD_DUMP 'd'=8'h64, CMD_RUN 'c'=8'h63.
//  IDLE: pipe_en = run_mode.
//   - run_mode=1: any rx_done_tick clears run_mode (halt); the byte is otherwise ignored.
//   - 's': pipe_en=1 for exactly one cycle (the cycle after the tick), then LOAD.
//   - 'd': -> LOAD next cycle. 'c': run_mode=1, stay IDLE. Other bytes: ignored.
//   - Accepting 's','d','c' clears tx_err.
//  LOAD: fifo_wr=1 for one cycle; byte counter cnt<=0; -> SEND.
//  SEND: if cnt==N_BYTES or fifo_empty -> TERM. Else same cycle: tx_data<=fifo_r_data,
//   tx_start=1, fifo_rd=1, cnt<=cnt+1, watchdog<=0 -> WAIT_TX.
//  WAIT_TX: watchdog++ each cycle; tx_done_tick -> SEND; watchdog==TX_TIMEOUT-1
//   without tick -> tx_err=1, -> IDLE (remaining FIFO bytes left unread).
//  TERM: tx_data<=8'h0A, tx_start=1 one cycle -> TERM_WAIT; tx_done_tick -> IDLE;
//   same watchdog rule as WAIT_TX.
//  Latency: command tick -> first tx_start = 3 cycles ('d'), 4 cycles ('s').
//  rx_done_tick while busy: dropped, no state effect. pipe_en=0 whenever busy.
//  tx_done_tick outside WAIT_TX/TERM_WAIT: ignored.
//  cnt width = $clog2(N_BYTES+1); never wraps (saturates at N_BYTES by construction).
//  watchdog width = $clog2(TX_TIMEOUT); compare on TX_TIMEOUT-1.
//  fifo_rd and fifo_wr never asserted in the same cycle; at most one tx_start per byte.
//  Reset mid-dump: immediate return to IDLE, outputs 0; FIFO pointers are not touched here.
// STRUCTURE
//  Shared package debug_pkg: state enum (IDLE, LOAD, SEND, WAIT_TX, TERM, TERM_WAIT),
//   command constants CMD_STEP/CMD_DUMP/CMD_RUN, TERM_BYTE=8'h0A.
//  Single FSM with registered state/cnt/watchdog/tx_data/run_mode/tx_err; next-state
//   logic in one combinational block. Optional sub-module: tx_watchdog (counter +
//   timeout compare), reused for WAIT_TX and TERM_WAIT.
// TESTING
//  1. Reset low mid-WAIT_TX -> all outputs 0 same cycle, IDLE after release, tx_err=0.
//  2. 'd', FIFO holds 8'h12,8'h34,8'h56,8'h78, tx_done 10 cycles after each start ->
//     tx_data sequence 12,34,56,78,0A; 4 fifo_rd pulses, 1 fifo_wr, busy low after.
//  3. 's' -> pipe_en high exactly 1 cycle, then fifo_wr, then dump as in 2.
//  4. 'c' -> pipe_en held 1; any byte (8'h00) -> pipe_en 0 next cycle, no dump started.
//  5. FIFO empty after 2 bytes during 'd' -> 2 data bytes then 0A; byte 'd' sent while
//     busy -> dropped (no second fifo_wr).
//  6. No tx_done_tick after first tx_start, TX_TIMEOUT=16 -> IDLE after 16 cycles,
//     tx_err=1; next 'd' clears tx_err and dumps normally.

Source files
------------

// File: rtl/debug_dump_ctrl_pkg.sv
// debug_pkg: shared states and command bytes for the debug dump sequencer.
package debug_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_TX, TERM, TERM_WAIT} state_t;
    localparam logic [7:0] CMD_STEP  = 8'h73;
    localparam logic [7:0] CMD_DUMP  = 8'h64;
    localparam logic [7:0] CMD_RUN   = 8'h63;
    localparam logic [7:0] TERM_BYTE = 8'h0A;
endpackage

// File: rtl/debug_dump_ctrl_if.sv
// debug_dump_ctrl_if: uart_rx / debug FIFO / uart_tx / pipeline signals around the sequencer.
interface debug_dump_ctrl_if #(parameter int B = 8);
    logic         rx_done_tick;
    logic [B-1:0] rx_data;
    logic         fifo_empty;
    logic [B-1:0] fifo_r_data;
    logic         tx_done_tick;
    logic         fifo_wr;
    logic         fifo_rd;
    logic         tx_start;
    logic [B-1:0] tx_data;
    logic         pipe_en;
    logic         busy;
    logic         tx_err;
    modport master (
        input  rx_done_tick, rx_data, fifo_empty, fifo_r_data, tx_done_tick,
        output fifo_wr, fifo_rd, tx_start, tx_data, pipe_en, busy, tx_err
    );
    modport slave (
        output rx_done_tick, rx_data, fifo_empty, fifo_r_data, tx_done_tick,
        input  fifo_wr, fifo_rd, tx_start, tx_data, pipe_en, busy, tx_err
    );
endinterface

// File: rtl/debug_dump_ctrl_tx_watchdog.sv
// tx_watchdog: per-byte transmit timeout counter, shared by WAIT_TX and TERM_WAIT.
module tx_watchdog #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WW-1:0] wd_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wd_q <= '0;
        else if (clr_i) wd_q <= '0;
        else if (en_i) wd_q <= wd_q + 1'b1;
    end
    assign expired_o = en_i && (wd_q == WW'(TIMEOUT - 1));
endmodule

// File: rtl/debug_dump_ctrl.sv
// debug_dump_ctrl: host command sequencer gating the pipeline and dumping the debug FIFO over UART.
module debug_dump_ctrl
    import debug_pkg::*;
#(
    parameter int B          = 8,
    parameter int N_BYTES    = 4,
    parameter int TX_TIMEOUT = 100000
) (
    input  logic          clk,
    input  logic          reset,
    debug_dump_ctrl_if.master bus
);
    localparam int CW = $clog2(N_BYTES + 1);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [B-1:0]  tx_data_q, tx_data_d;
    logic          run_q, run_d, err_q, err_d, step_q, step_d;
    logic          wr_q, wr_d, rd_q, rd_d, start_q, start_d, pe_q, pe_d, busy_q, busy_d;
    logic          wd_clr, wd_en, wd_expired;
    assign wd_en = (state_q == WAIT_TX) || (state_q == TERM_WAIT);
    tx_watchdog #(.TIMEOUT(TX_TIMEOUT)) u_wd (
        .clk(clk), .reset(reset), .clr_i(wd_clr), .en_i(wd_en), .expired_o(wd_expired)
    );
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        run_d     = run_q;
        err_d     = err_q;
        step_d    = 1'b0;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        start_d   = 1'b0;
        wd_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                // a step pulse owns the cycle after its command; bytes arriving then are dropped
                if (step_q) begin
                    state_d = LOAD;
                    wr_d    = 1'b1;
                end else if (bus.rx_done_tick) begin
                    if (run_q) run_d = 1'b0;
                    else if (bus.rx_data == B'(CMD_STEP)) begin
                        step_d = 1'b1;
                        err_d  = 1'b0;
                    end else if (bus.rx_data == B'(CMD_DUMP)) begin
                        state_d = LOAD;
                        wr_d    = 1'b1;
                        err_d   = 1'b0;
                    end else if (bus.rx_data == B'(CMD_RUN)) begin
                        run_d = 1'b1;
                        err_d = 1'b0;
                    end
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (cnt_q == CW'(N_BYTES) || bus.fifo_empty) state_d = TERM;
                else begin
                    tx_data_d = bus.fifo_r_data;
                    start_d   = 1'b1;
                    rd_d      = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    wd_clr    = 1'b1;
                    state_d   = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (bus.tx_done_tick) state_d = SEND;
                else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            TERM: begin
                tx_data_d = B'(TERM_BYTE);
                start_d   = 1'b1;
                wd_clr    = 1'b1;
                state_d   = TERM_WAIT;
            end
            TERM_WAIT: begin
                if (bus.tx_done_tick) state_d = IDLE;
                else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pe_d   = (state_d == IDLE) && (run_d || step_d);
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_data_q <= '0;
            run_q     <= 1'b0;
            err_q     <= 1'b0;
            step_q    <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            start_q   <= 1'b0;
            pe_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            run_q     <= run_d;
            err_q     <= err_d;
            step_q    <= step_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            start_q   <= start_d;
            pe_q      <= pe_d;
            busy_q    <= busy_d;
        end
    end
    assign bus.fifo_wr  = wr_q;
    assign bus.fifo_rd  = rd_q;
    assign bus.tx_start = start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.pipe_en  = pe_q;
    assign bus.busy     = busy_q;
    assign bus.tx_err   = err_q;
endmodule

// File: tb/tb_debug_dump_ctrl.sv
// tb_debug_dump_ctrl: directed checks of command decode, dump sequencing, timeout and reset.
module tb_debug_dump_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    debug_dump_ctrl_if #(.B(8)) bus ();
    debug_dump_ctrl #(.B(8), .N_BYTES(4), .TX_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    logic [7:0] mem [16];
    logic [3:0] rp = '0, wp = '0;
    logic [7:0] snap [4];
    logic [3:0] snap_n = 4'd4;
    assign bus.fifo_empty  = (rp == wp);
    assign bus.fifo_r_data = mem[rp];
    always @(posedge clk) begin
        if (bus.fifo_wr) begin
            for (int i = 0; i < 4; i++) if (4'(i) < snap_n) mem[4'(wp + 4'(i))] <= snap[i];
            wp <= wp + snap_n;
        end
        if (bus.fifo_rd) rp <= rp + 4'd1;
    end
    int cyc = 0;
    always @(posedge clk) cyc++;
    int n_start = 0, n_wr = 0, n_rd = 0, n_pe = 0, wr_cyc = 0, pe_cyc = 0, cd = 0;
    int start_cyc [64];
    logic [7:0] log_b [64];
    bit tx_resp = 1'b1;
    // UART tx model answers each start with tx_done 10 cycles later
    always @(negedge clk) begin
        bus.tx_done_tick = 1'b0;
        if (!reset) cd = 0;
        else if (bus.tx_start) begin
            start_cyc[n_start] = cyc;
            log_b[n_start] = bus.tx_data;
            n_start++;
            cd = tx_resp ? 10 : 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) bus.tx_done_tick = 1'b1;
        end
        if (bus.fifo_wr) begin n_wr++; wr_cyc = cyc; end
        if (bus.fifo_rd) n_rd++;
        if (bus.pipe_en) begin n_pe++; pe_cyc = cyc; end
    end
    int n_chk = 0, n_err = 0;
    int tick_cyc, idle_cyc, b_s, b_w, b_r, b_p;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    task automatic send_rx(input logic [7:0] b);
        step();
        bus.rx_data = b;
        bus.rx_done_tick = 1'b1;
        tick_cyc = cyc;
        step();
        bus.rx_done_tick = 1'b0;
    endtask
    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (!bus.busy) break;
        end
        idle_cyc = cyc;
        check("idle_reached", {31'd0, bus.busy}, 32'd0);
    endtask
    task automatic base();
        b_s = n_start; b_w = n_wr; b_r = n_rd; b_p = n_pe;
    endtask
    task automatic outs_zero(input string tag);
        check(tag, {bus.fifo_wr, bus.fifo_rd, bus.tx_start, bus.pipe_en, bus.busy, bus.tx_err, bus.tx_data}, 32'd0);
    endtask
    task automatic check_log(input string tag, input int n, input logic [39:0] exp);
        for (int i = 0; i < n; i++) check(tag, {24'd0, log_b[b_s + i]}, {24'd0, exp[39 - 8*i -: 8]});
    endtask
    initial begin
        bus.rx_done_tick = 1'b0;
        bus.rx_data = '0;
        bus.tx_done_tick = 1'b0;
        snap[0] = 8'h12; snap[1] = 8'h34; snap[2] = 8'h56; snap[3] = 8'h78;
        step();
        outs_zero("reset_outs");
        step();
        reset = 1'b1;
        step();
        outs_zero("post_reset_outs");
        // full dump via 'd'
        base();
        send_rx(8'h64);
        wait_idle(200);
        check("d_latency", start_cyc[b_s] - tick_cyc, 3);
        check_log("d_bytes", 5, 40'h12345678_0A);
        check("d_starts", n_start - b_s, 5);
        check("d_rd", n_rd - b_r, 4);
        check("d_wr", n_wr - b_w, 1);
        check("d_pipe_en", n_pe - b_p, 0);
        // single step then dump
        base();
        send_rx(8'h73);
        check("s_pe_cycle", pe_cyc - tick_cyc, 1);
        step();
        wait_idle(200);
        check("s_pe_count", n_pe - b_p, 1);
        check("s_wr_cycle", wr_cyc - tick_cyc, 2);
        check("s_latency", start_cyc[b_s] - tick_cyc, 4);
        check_log("s_bytes", 5, 40'h12345678_0A);
        check("s_rd", n_rd - b_r, 4);
        // run, then halt with any byte
        base();
        send_rx(8'h63);
        check("c_pe_on", {31'd0, bus.pipe_en}, 1);
        repeat (5) step();
        check("c_pe_held", {31'd0, bus.pipe_en}, 1);
        send_rx(8'h00);
        check("halt_pe_off", {31'd0, bus.pipe_en}, 0);
        check("halt_busy", {31'd0, bus.busy}, 0);
        step();
        check("halt_no_dump", n_wr - b_w, 0);
        // FIFO runs dry after two bytes; a 'd' while busy is dropped
        snap[0] = 8'hAA; snap[1] = 8'hBB; snap_n = 4'd2;
        base();
        send_rx(8'h64);
        for (int i = 0; i < 20 && n_start == b_s; i++) step();
        send_rx(8'h64);
        wait_idle(200);
        check_log("empty_bytes", 3, 40'hAABB0A_0000);
        check("empty_starts", n_start - b_s, 3);
        check("empty_rd", n_rd - b_r, 2);
        check("busy_drop_wr", n_wr - b_w, 1);
        // timeout on first byte, then recovery
        snap[0] = 8'h12; snap[1] = 8'h34; snap_n = 4'd4;
        tx_resp = 1'b0;
        base();
        send_rx(8'h64);
        wait_idle(100);
        check("to_cycles", idle_cyc - start_cyc[b_s], 16);
        check("to_err", {31'd0, bus.tx_err}, 1);
        check("to_rd", n_rd - b_r, 1);
        check("to_starts", n_start - b_s, 1);
        tx_resp = 1'b1;
        base();
        send_rx(8'h64);
        check("err_cleared", {31'd0, bus.tx_err}, 0);
        wait_idle(200);
        check_log("cap_bytes", 5, 40'h34567812_0A);
        check("cap_rd", n_rd - b_r, 4);
        // async reset in the middle of WAIT_TX
        tx_resp = 1'b0;
        base();
        send_rx(8'h64);
        for (int i = 0; i < 20 && n_start == b_s; i++) step();
        step();
        check("mid_busy", {31'd0, bus.busy}, 1);
        reset = 1'b0;
        #1;
        outs_zero("mid_reset_outs");
        step();
        reset = 1'b1;
        tx_resp = 1'b1;
        step();
        check("rel_busy", {31'd0, bus.busy}, 0);
        check("rel_err", {31'd0, bus.tx_err}, 0);
        send_rx(8'h63);
        check("rel_cmd_ok", {31'd0, bus.pipe_en}, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
